// File: rtl/alu_control_md_if.sv
// alu_control_md_if: req/ack/done handshake between the EX-stage ALU control and the
// iterative mul/div unit.
interface alu_control_md_if;
    logic       md_req;
    logic [2:0] md_op;
    logic       md_ack;
    logic       md_done;
    logic       md_abort;
    modport master (output md_req, md_op, md_abort, input md_ack, md_done);
    modport slave  (input md_req, md_op, md_abort, output md_ack, md_done);
endinterface

// File: rtl/alu_control_md.sv
// alu_control_md: RV32I ALU function decode plus RV32M sequencing to an iterative
// mul/div unit, with pipeline stall, completed-op counter, decode-error and timeout flags.
module alu_control_md #(
    parameter int FUNC_W     = 4,
    parameter int EN_M       = 1,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [1:0]        alu_op,
    input  logic [6:0]        funct7,
    input  logic [2:0]        funct3,
    output logic [FUNC_W-1:0] alu_func,
    alu_control_md_if.master  md,
    output logic              md_sel,
    output logic              stall,
    output logic              illegal,
    output logic              timeout,
    output logic [CNT_W-1:0]  md_count
);
    localparam logic [FUNC_W-1:0] OP_ADD  = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] OP_SUB  = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] OP_SLL  = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] OP_SLT  = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] OP_SLTU = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] OP_XOR  = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] OP_SRL  = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] OP_SRA  = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] OP_OR   = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] OP_AND  = FUNC_W'(9);
    localparam logic [FUNC_W-1:0] OP_BGE  = FUNC_W'(10);
    localparam logic [FUNC_W-1:0] OP_BGEU = FUNC_W'(11);
    localparam logic [FUNC_W-1:0] OP_EEE  = FUNC_W'(15);
    localparam int WCNT_W = $clog2(MD_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             state;
    logic [WCNT_W-1:0]  wcnt;
    logic               is_m;
    logic               f7_ok;
    logic               start;
    logic [FUNC_W-1:0]  r_func;
    logic [FUNC_W-1:0]  i_func;

    always_comb begin
        is_m  = EN_M != 0 && alu_op == 2'b10 && funct7 == 7'h01;
        f7_ok = funct7 == 7'h00 || funct7 == 7'h20;
        case ({funct7[5], funct3})
            4'b0_000: r_func = OP_ADD;
            4'b1_000: r_func = OP_SUB;
            4'b0_001: r_func = OP_SLL;
            4'b0_010: r_func = OP_SLT;
            4'b0_011: r_func = OP_SLTU;
            4'b0_100: r_func = OP_XOR;
            4'b0_101: r_func = OP_SRL;
            4'b1_101: r_func = OP_SRA;
            4'b0_110: r_func = OP_OR;
            4'b0_111: r_func = OP_AND;
            default:  r_func = OP_EEE;
        endcase
        // only the immediate shifts carry an encoding in funct7
        case (funct3)
            3'b000:  i_func = OP_ADD;
            3'b001:  i_func = funct7 == 7'h00 ? OP_SLL : OP_EEE;
            3'b010:  i_func = OP_SLT;
            3'b011:  i_func = OP_SLTU;
            3'b100:  i_func = OP_XOR;
            3'b101:  i_func = funct7 == 7'h00 ? OP_SRL : funct7 == 7'h20 ? OP_SRA : OP_EEE;
            3'b110:  i_func = OP_OR;
            default: i_func = OP_AND;
        endcase
        case (alu_op)
            2'b00:   alu_func = OP_ADD;
            2'b01:   alu_func = funct3[2:1] == 2'b00 ? OP_SUB :
                                funct3[2:1] == 2'b10 ? OP_BGE :
                                funct3[2:1] == 2'b11 ? OP_BGEU : OP_EEE;
            2'b10:   alu_func = is_m ? OP_ADD : f7_ok ? r_func : OP_EEE;
            default: alu_func = i_func;
        endcase
    end

    assign start = state == S_IDLE && in_valid && is_m && !flush;
    assign stall = start || state == S_REQ || state == S_WAIT;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            md.md_req   <= 1'b0;
            md.md_op    <= 3'b000;
            md.md_abort <= 1'b0;
            md_sel      <= 1'b0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            md_count    <= '0;
        end else begin
            illegal     <= in_valid && !flush && state == S_IDLE && alu_func == OP_EEE;
            md.md_abort <= 1'b0;
            md_sel      <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state     <= S_REQ;
                    md.md_req <= 1'b1;
                    md.md_op  <= funct3;
                    wcnt      <= '0;
                end
                S_REQ: if (flush) begin
                    state       <= S_IDLE;
                    md.md_req   <= 1'b0;
                    md.md_abort <= md.md_ack;
                end else if (md.md_ack) begin
                    md.md_req <= 1'b0;
                    state     <= md.md_done ? S_DONE : S_WAIT;
                    md_sel    <= md.md_done;
                    if (md.md_done)
                        md_count <= md_count == '1 ? md_count : md_count + 1'b1;
                end
                S_WAIT: if (flush) begin
                    state       <= S_IDLE;
                    md.md_abort <= 1'b1;
                end else if (md.md_done) begin
                    state    <= S_DONE;
                    md_sel   <= 1'b1;
                    md_count <= md_count == '1 ? md_count : md_count + 1'b1;
                end else if (wcnt == WCNT_W'(MD_TIMEOUT - 1)) begin
                    state       <= S_IDLE;
                    timeout     <= 1'b1;
                    md.md_abort <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_md.sv
// tb_alu_control_md: directed and randomized checks of alu_control_md against an
// instruction-table decode model and a transaction-level mul/div sequencing model.
module tb_alu_control_md;
    localparam int TO = 4;
    localparam int CMAX = 3;
    localparam logic [3:0] ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR = 5, SRL = 6,
                           SRA = 7, OR = 8, AND = 9, BGE = 10, BGEU = 11, EEE = 15;

    logic       clk, rstn, in_valid, flush;
    logic [1:0] alu_op;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [3:0] alu_func, alu_func0;
    logic       md_sel, stall, illegal, timeout;
    logic       md_sel0, stall0, illegal0, timeout0;
    logic [1:0] md_count;
    logic [3:0] md_count0;

    alu_control_md_if mif();
    alu_control_md_if mif0();

    alu_control_md #(.FUNC_W(4), .EN_M(1), .MD_TIMEOUT(TO), .CNT_W(2)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .flush(flush), .alu_op(alu_op),
        .funct7(funct7), .funct3(funct3), .alu_func(alu_func), .md(mif.master),
        .md_sel(md_sel), .stall(stall), .illegal(illegal), .timeout(timeout),
        .md_count(md_count));

    alu_control_md #(.FUNC_W(4), .EN_M(0), .MD_TIMEOUT(TO), .CNT_W(4)) dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .flush(flush), .alu_op(alu_op),
        .funct7(funct7), .funct3(funct3), .alu_func(alu_func0), .md(mif0.master),
        .md_sel(md_sel0), .stall(stall0), .illegal(illegal0), .timeout(timeout0),
        .md_count(md_count0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // {funct7, funct3, code} for legal R-type instructions
    logic [13:0] rtab [10] = '{
        {7'h00, 3'd0, ADD}, {7'h20, 3'd0, SUB}, {7'h00, 3'd1, SLL}, {7'h00, 3'd2, SLT},
        {7'h00, 3'd3, SLTU}, {7'h00, 3'd4, XOR}, {7'h00, 3'd5, SRL}, {7'h20, 3'd5, SRA},
        {7'h00, 3'd6, OR}, {7'h00, 3'd7, AND}};
    // {funct7 matters, funct7, funct3, code} for legal I-type instructions
    logic [14:0] itab [9] = '{
        {1'b0, 7'h00, 3'd0, ADD}, {1'b0, 7'h00, 3'd2, SLT}, {1'b0, 7'h00, 3'd3, SLTU},
        {1'b0, 7'h00, 3'd4, XOR}, {1'b0, 7'h00, 3'd6, OR}, {1'b0, 7'h00, 3'd7, AND},
        {1'b1, 7'h00, 3'd1, SLL}, {1'b1, 7'h00, 3'd5, SRL}, {1'b1, 7'h20, 3'd5, SRA}};

    function automatic logic [3:0] ref_dec(input logic [1:0] op, input logic [6:0] f7,
                                           input logic [2:0] f3, input bit en_m);
        if (op == 2'd0) return ADD;
        if (op == 2'd1) return (f3 < 2) ? SUB : (f3 == 4 || f3 == 5) ? BGE :
                               (f3 >= 6) ? BGEU : EEE;
        if (op == 2'd2) begin
            if (en_m && f7 == 7'h01) return ADD;
            foreach (rtab[i]) if (rtab[i][13:7] == f7 && rtab[i][6:4] == f3) return rtab[i][3:0];
            return EEE;
        end
        foreach (itab[i])
            if (itab[i][6:4] == f3 && (!itab[i][14] || itab[i][13:7] == f7)) return itab[i][3:0];
        return EEE;
    endfunction

    // model: an op is either being requested, in flight (acked), or retiring for one cycle
    bit m_req, m_inf, m_sel, m_abort, m_ill, m_to, m_ill0;
    int m_age, m_cnt;
    logic [2:0] m_op;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cmp_regs();
        cmp("md_req", mif.md_req, m_req);
        cmp("md_op", mif.md_op, m_op);
        cmp("md_abort", mif.md_abort, m_abort);
        cmp("md_sel", md_sel, m_sel);
        cmp("illegal", illegal, m_ill);
        cmp("timeout", timeout, m_to);
        cmp("md_count", md_count, m_cnt);
        cmp("illegal_nom", illegal0, m_ill0);
        cmp("md_req_nom", mif0.md_req, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        {m_req, m_inf, m_sel, m_abort, m_ill, m_to, m_ill0} = '0;
        m_age = 0;
        m_cnt = 0;
        m_op = 3'd0;
        cmp_regs();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic step();
        logic [3:0] d, d0;
        bit idle, fin, n_req, n_inf, n_sel, n_abort, n_to;
        int n_age, n_cnt;
        logic [2:0] n_op;
        #1;
        d = ref_dec(alu_op, funct7, funct3, 1'b1);
        d0 = ref_dec(alu_op, funct7, funct3, 1'b0);
        idle = !m_req && !m_inf && !m_sel;
        cmp("alu_func", alu_func, d);
        cmp("alu_func_nom", alu_func0, d0);
        cmp("stall", stall, m_req || m_inf ||
            (idle && in_valid && alu_op == 2 && funct7 == 7'h01 && !flush));
        cmp("stall_nom", stall0, 0);
        cmp_regs();
        {n_req, n_inf, n_to} = {m_req, m_inf, m_to};
        {fin, n_sel, n_abort} = '0;
        n_age = m_age;
        n_cnt = m_cnt;
        n_op = m_op;
        if (m_req) begin
            if (flush) begin n_req = 0; n_abort = mif.md_ack; end
            else if (mif.md_ack) begin
                n_req = 0;
                if (mif.md_done) fin = 1; else begin n_inf = 1; n_age = 0; end
            end
        end else if (m_inf) begin
            if (flush) begin n_inf = 0; n_abort = 1; end
            else if (mif.md_done) begin n_inf = 0; fin = 1; end
            else if (m_age == TO - 1) begin n_inf = 0; n_to = 1; n_abort = 1; end
            else n_age = m_age + 1;
        end else if (idle && in_valid && alu_op == 2 && funct7 == 7'h01 && !flush) begin
            n_req = 1;
            n_op = funct3;
        end
        if (fin) begin n_sel = 1; n_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX; end
        @(posedge clk);
        m_ill = in_valid && !flush && idle && d == EEE;
        m_ill0 = in_valid && !flush && d0 == EEE;
        {m_req, m_inf, m_sel, m_abort, m_to} = {n_req, n_inf, n_sel, n_abort, n_to};
        m_age = n_age;
        m_cnt = n_cnt;
        m_op = n_op;
        @(negedge clk);
    endtask

    task automatic set_instr(input logic v, input logic [1:0] op, input logic [6:0] f7,
                             input logic [2:0] f3);
        in_valid = v; alu_op = op; funct7 = f7; funct3 = f3;
    endtask

    initial begin
        rstn = 1'b1; flush = 1'b0;
        set_instr(0, 2'd0, 7'h00, 3'd0);
        mif.md_ack = 0; mif.md_done = 0; mif0.md_ack = 0; mif0.md_done = 0;
        @(negedge clk);
        do_reset();

        set_instr(1, 2'd2, 7'h20, 3'd5);
        #1; cmp("sra_func", alu_func, SRA); cmp("sra_stall", stall, 0);
        step(); cmp("sra_illegal", illegal, 0); cmp("sra_req", mif.md_req, 0);

        set_instr(1, 2'd2, 7'h01, 3'd0);
        #1; cmp("mul_stall0", stall, 1);
        step(); cmp("mul_req1", mif.md_req, 1);
        step();
        mif.md_ack = 1; step(); mif.md_ack = 0;
        step(); step();
        mif.md_done = 1; step(); mif.md_done = 0;
        in_valid = 0;
        #1; cmp("mul_sel", md_sel, 1); cmp("mul_stall6", stall, 0);
        cmp("mul_op", mif.md_op, 0); cmp("mul_count", md_count, 1);
        step();

        set_instr(1, 2'd2, 7'h01, 3'd5);
        step();
        mif.md_ack = 1; mif.md_done = 1; step(); mif.md_ack = 0; mif.md_done = 0;
        in_valid = 0;
        cmp("divu_sel", md_sel, 1); cmp("divu_count", md_count, 2); cmp("divu_op", mif.md_op, 5);
        step();

        set_instr(1, 2'd2, 7'h01, 3'd6);
        step();
        mif.md_ack = 1; step(); mif.md_ack = 0;
        step();
        flush = 1; step(); flush = 0; in_valid = 0;
        #1; cmp("flush_abort", mif.md_abort, 1); cmp("flush_stall", stall, 0);
        cmp("flush_count", md_count, 2); cmp("flush_req", mif.md_req, 0);
        step(); cmp("flush_abort_end", mif.md_abort, 0);

        set_instr(1, 2'd2, 7'h01, 3'd1);
        step();
        mif.md_ack = 1; step(); mif.md_ack = 0;
        repeat (4) step();
        in_valid = 0;
        cmp("to_flag", timeout, 1); cmp("to_abort", mif.md_abort, 1); cmp("to_req", mif.md_req, 0);
        step(); cmp("to_sticky", timeout, 1); cmp("to_abort_end", mif.md_abort, 0);

        repeat (3) begin
            set_instr(1, 2'd2, 7'h01, 3'd0);
            step();
            in_valid = 0; mif.md_ack = 1; mif.md_done = 1;
            step();
            mif.md_ack = 0; mif.md_done = 0;
            step();
        end
        cmp("sat_count", md_count, 3);

        set_instr(1, 2'd3, 7'h20, 3'd1);
        #1; cmp("slli_func", alu_func, EEE);
        step(); cmp("slli_illegal", illegal, 1);
        in_valid = 0;
        step(); cmp("slli_illegal_end", illegal, 0);

        set_instr(1, 2'd2, 7'h01, 3'd0);
        #1; cmp("nom_func", alu_func0, EEE); cmp("m_func", alu_func, ADD);
        step(); cmp("nom_illegal", illegal0, 1); cmp("m_illegal", illegal, 0);
        in_valid = 0;
        do_reset();
        cmp("rst_timeout", timeout, 0); cmp("rst_count", md_count, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            in_valid = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
            alu_op = 2'($urandom);
            case ($urandom_range(0, 3))
                0: funct7 = 7'h00;
                1: funct7 = 7'h20;
                2: funct7 = 7'h01;
                default: funct7 = 7'($urandom);
            endcase
            funct3 = 3'($urandom);
            mif.md_ack = ($urandom_range(0, 2) == 0);
            mif.md_done = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
